// File: rtl/issp_cmd_queue_if.sv
// ---------------------------------------------------------------------------
// issp_cmd_queue_if
// Bundles the host-side byte-write bus, the result FIFO read port, the status
// outputs and the ISSP bit-engine handshake of issp_cmd_queue.
//
// Handshake semantics (host and engine):
//   wr_en     : single-cycle strobe, qualifies wr_sel/wr_data for one cycle.
//   res_pop   : single-cycle strobe, drops the result head when res_valid=1,
//               ignored otherwise.
//   eng_start : single-cycle pulse from the queue; eng_cmd/eng_vec/eng_mask
//               are valid on that cycle and held until the next start.
//   eng_done  : single-cycle pulse from the engine; eng_result is sampled on
//               that cycle only, and only while a command is outstanding.
//
// Modports
//   master : host + engine side (testbench / surrounding logic)
//   slave  : the queue itself
// ---------------------------------------------------------------------------
interface issp_cmd_queue_if #(
    parameter int DEPTH_LOG2 = 3,
    parameter int VEC_W      = 22,
    parameter int CMD_W      = 3
);
    // host write bus
    logic                  wr_en;
    logic [2:0]            wr_sel;
    logic [7:0]            wr_data;
    // result FIFO read port
    logic                  res_pop;
    logic [VEC_W-1:0]      res_vec;
    logic                  res_valid;
    // status
    logic [DEPTH_LOG2:0]   cmd_count;
    logic [DEPTH_LOG2:0]   res_count;
    logic                  ovf;
    logic                  busy;
    logic [1:0]            dbg_state;
    // engine handshake
    logic [CMD_W-1:0]      eng_cmd;
    logic [VEC_W-1:0]      eng_vec;
    logic [VEC_W-1:0]      eng_mask;
    logic                  eng_start;
    logic                  eng_done;
    logic [VEC_W-1:0]      eng_result;

    modport master (
        output wr_en, wr_sel, wr_data, res_pop, eng_done, eng_result,
        input  res_vec, res_valid, cmd_count, res_count, ovf, busy, dbg_state,
               eng_cmd, eng_vec, eng_mask, eng_start
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, res_pop, eng_done, eng_result,
        output res_vec, res_valid, cmd_count, res_count, ovf, busy, dbg_state,
               eng_cmd, eng_vec, eng_mask, eng_start
    );
endinterface

// File: rtl/issp_cmd_queue.sv
// ---------------------------------------------------------------------------
// issp_cmd_queue
// Command/vector queue in front of the M8C ISSP bit engine. The host stages a
// vector and a receive mask byte by byte, then pushes {cmd, vec, mask} into a
// command FIFO. A dispatch FSM hands one entry at a time to the engine and
// stores SENDVEC read-back vectors (non-zero mask) in a result FIFO.
//
// Ports
//   osc    : clock, all logic on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : issp_cmd_queue_if.slave
//              wr_en/wr_sel/wr_data : host byte writes
//                sel 0 push cmd, 1..3 vec lo/med/hi, 4..6 mask lo/med/hi,
//                sel 7 ctrl ([0] flush, [1] clear ovf)
//              res_pop/res_vec/res_valid/res_count : result FIFO
//              cmd_count/ovf/busy/dbg_state        : status
//              eng_cmd/eng_vec/eng_mask/eng_start/eng_done/eng_result : engine
// ---------------------------------------------------------------------------
module issp_cmd_queue #(
    parameter int DEPTH_LOG2 = 3,
    parameter int VEC_W      = 22,
    parameter int CMD_W      = 3
) (
    input  logic             osc,
    input  logic             rst_n,
    issp_cmd_queue_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ENT_W = CMD_W + 2 * VEC_W;

    localparam logic [DEPTH_LOG2:0]   FULL_CNT    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE     = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
    localparam logic [CMD_W-1:0]      CMD_SENDVEC = CMD_W'(3);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t state, next_state;

    // -----------------------------------------------------------------------
    // Host write decode
    // -----------------------------------------------------------------------
    logic host_push, host_ctrl, flush, clr_ovf;

    assign host_push = bus.wr_en && (bus.wr_sel == 3'd0);
    assign host_ctrl = bus.wr_en && (bus.wr_sel == 3'd7);
    assign flush     = host_ctrl && bus.wr_data[0];
    assign clr_ovf   = host_ctrl && bus.wr_data[1];

    // -----------------------------------------------------------------------
    // Staging registers: persist across pushes so a run of commands can
    // share one vector/mask.
    // -----------------------------------------------------------------------
    logic [VEC_W-1:0] vec_q, mask_q;

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            mask_q <= '0;
        end else if (bus.wr_en) begin
            case (bus.wr_sel)
                3'd1: vec_q[7:0]         <= bus.wr_data;
                3'd2: vec_q[15:8]        <= bus.wr_data;
                3'd3: vec_q[VEC_W-1:16]  <= bus.wr_data[VEC_W-17:0];
                3'd4: mask_q[7:0]        <= bus.wr_data;
                3'd5: mask_q[15:8]       <= bus.wr_data;
                3'd6: mask_q[VEC_W-1:16] <= bus.wr_data[VEC_W-17:0];
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    logic [ENT_W-1:0]      cmd_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [DEPTH_LOG2:0]   cmd_cnt;
    logic                  cmd_full, cmd_empty, cmd_push_ok, cmd_pop;
    logic [ENT_W-1:0]      cmd_head;
    logic [CMD_W-1:0]      head_cmd;
    logic [VEC_W-1:0]      head_vec, head_mask;
    logic                  ovf_q;

    assign cmd_full    = (cmd_cnt == FULL_CNT);
    assign cmd_empty   = (cmd_cnt == '0);
    // Full is judged on the pre-edge count, so a same-cycle pop never makes
    // room for a push. Flush takes priority over a coincident push.
    assign cmd_push_ok = host_push && !cmd_full && !flush;
    assign cmd_head    = cmd_mem[cmd_rd_ptr];
    assign head_cmd    = cmd_head[ENT_W-1 -: CMD_W];
    assign head_vec    = cmd_head[2*VEC_W-1 -: VEC_W];
    assign head_mask   = cmd_head[VEC_W-1:0];

    always_ff @(posedge osc) begin
        if (cmd_push_ok)
            cmd_mem[cmd_wr_ptr] <= {bus.wr_data[CMD_W-1:0], vec_q, mask_q};
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_cnt    <= '0;
        end else if (flush) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_cnt    <= '0;
        end else begin
            if (cmd_push_ok) cmd_wr_ptr <= cmd_wr_ptr + PTR_ONE;
            if (cmd_pop)     cmd_rd_ptr <= cmd_rd_ptr + PTR_ONE;
            case ({cmd_push_ok, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + CNT_ONE;
                2'b01:   cmd_cnt <= cmd_cnt - CNT_ONE;
                default: cmd_cnt <= cmd_cnt;
            endcase
        end
    end

    // Sticky overflow; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n)                    ovf_q <= 1'b0;
        else if (host_push && cmd_full) ovf_q <= 1'b1;
        else if (clr_ovf)              ovf_q <= 1'b0;
    end

    // -----------------------------------------------------------------------
    // Result FIFO
    // -----------------------------------------------------------------------
    logic [VEC_W-1:0]      res_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] res_wr_ptr, res_rd_ptr;
    logic [DEPTH_LOG2:0]   res_cnt;
    logic                  res_full, res_empty, res_pop_ok, res_push;
    logic [VEC_W-1:0]      res_data_q;

    assign res_full   = (res_cnt == FULL_CNT);
    assign res_empty  = (res_cnt == '0);
    assign res_pop_ok = bus.res_pop && !res_empty;

    always_ff @(posedge osc) begin
        if (res_push)
            res_mem[res_wr_ptr] <= res_data_q;
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_cnt    <= '0;
        end else if (flush) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_cnt    <= '0;
        end else begin
            if (res_push)   res_wr_ptr <= res_wr_ptr + PTR_ONE;
            if (res_pop_ok) res_rd_ptr <= res_rd_ptr + PTR_ONE;
            case ({res_push, res_pop_ok})
                2'b10:   res_cnt <= res_cnt + CNT_ONE;
                2'b01:   res_cnt <= res_cnt - CNT_ONE;
                default: res_cnt <= res_cnt;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Dispatch FSM
    // -----------------------------------------------------------------------
    logic [CMD_W-1:0] eng_cmd_q;
    logic [VEC_W-1:0] eng_vec_q, eng_mask_q;
    logic             keep_q, discard_q, keep_eff;
    logic             load_eng, capture, eng_start;

    // A flush anywhere between issue and result push throws the result away.
    assign keep_eff = keep_q && !discard_q && !flush;

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        eng_start  = 1'b0;
        cmd_pop    = 1'b0;
        res_push   = 1'b0;
        load_eng   = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                // The head is latched here so it is stable for the whole
                // ISSUE/WAIT window. Skip if a flush is emptying the FIFO.
                if (!cmd_empty && !flush) begin
                    load_eng   = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start  = 1'b1;
                cmd_pop    = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (bus.eng_done) begin
                    capture    = 1'b1;
                    next_state = S_RESULT;
                end
            end
            S_RESULT: begin
                // Stall rather than drop when the result FIFO is full.
                if (!(keep_eff && res_full)) begin
                    res_push   = keep_eff;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            eng_cmd_q  <= '0;
            eng_vec_q  <= '0;
            eng_mask_q <= '0;
            keep_q     <= 1'b0;
            res_data_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            if (load_eng) begin
                eng_cmd_q  <= head_cmd;
                eng_vec_q  <= head_vec;
                eng_mask_q <= head_mask;
            end
            if (capture) begin
                res_data_q <= bus.eng_result;
                keep_q     <= (eng_cmd_q == CMD_SENDVEC) && (eng_mask_q != '0);
            end
            if (state == S_RESULT && next_state == S_IDLE)
                discard_q <= 1'b0;
            else if (flush && state != S_IDLE)
                discard_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.res_vec   = res_empty ? '0 : res_mem[res_rd_ptr];
    assign bus.res_valid = !res_empty;
    assign bus.cmd_count = cmd_cnt;
    assign bus.res_count = res_cnt;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (state != S_IDLE) || !cmd_empty;
    assign bus.dbg_state = state;
    assign bus.eng_cmd   = eng_cmd_q;
    assign bus.eng_vec   = eng_vec_q;
    assign bus.eng_mask  = eng_mask_q;
    assign bus.eng_start = eng_start;

endmodule

// File: tb/tb_issp_cmd_queue.sv
`timescale 1ns/1ps
module tb_issp_cmd_queue;
  localparam int DEPTH_LOG2 = 3;
  localparam int VEC_W      = 22;
  localparam int CMD_W      = 3;
  localparam int DEPTH      = 8;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [VEC_W-1:0] vec;
    logic [VEC_W-1:0] mask;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic osc   = 1'b0;
  logic rst_n = 1'b0;
  always #20.833 osc = ~osc;

  issp_cmd_queue_if #(.DEPTH_LOG2(DEPTH_LOG2), .VEC_W(VEC_W), .CMD_W(CMD_W)) bus ();

  issp_cmd_queue #(.DEPTH_LOG2(DEPTH_LOG2), .VEC_W(VEC_W), .CMD_W(CMD_W)) dut (
    .osc   (osc),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // scoreboard: expected result vectors in FIFO order
  logic [VEC_W-1:0] exp_q[$];
  // every engine start seen, sampled mid-cycle
  ent_t start_log[$];

  always @(negedge osc) begin
    if (rst_n && bus.eng_start)
      start_log.push_back({bus.eng_cmd, bus.eng_vec, bus.eng_mask});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge osc);
    #1;
  endtask

  task automatic wr_byte(input logic [2:0] sel, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 3'd0;
    bus.wr_data = 8'd0;
  endtask

  task automatic stage(input logic [VEC_W-1:0] v, input logic [VEC_W-1:0] m);
    wr_byte(3'd1, v[7:0]);
    wr_byte(3'd2, v[15:8]);
    wr_byte(3'd3, {2'b00, v[21:16]});
    wr_byte(3'd4, m[7:0]);
    wr_byte(3'd5, m[15:8]);
    wr_byte(3'd6, {2'b00, m[21:16]});
  endtask

  task automatic push(input logic [CMD_W-1:0] c);
    wr_byte(3'd0, {5'd0, c});
  endtask

  task automatic pulse_done(input logic [VEC_W-1:0] r);
    bus.eng_done   = 1'b1;
    bus.eng_result = r;
    tick();
    bus.eng_done   = 1'b0;
    bus.eng_result = VEC_W'($urandom);
  endtask

  task automatic pop_res();
    bus.res_pop = 1'b1;
    tick();
    bus.res_pop = 1'b0;
  endtask

  task automatic wait_starts(input int n, output bit ok);
    int b;
    b = 0;
    while (start_log.size() < n && b < 40) begin
      tick();
      b++;
    end
    ok = (start_log.size() >= n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    start_log.delete();
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    chk_cnt++; if ({bus.res_valid, bus.res_count, bus.cmd_count, bus.ovf, bus.busy, bus.eng_start} !== '0)
      $display("FAIL reset_status: got %h exp 0", {bus.res_valid, bus.res_count, bus.cmd_count, bus.ovf, bus.busy, bus.eng_start}); else pass_cnt++;
    chk_cnt++; if (bus.res_vec !== '0) $display("FAIL reset_res_vec: got %h exp 0", bus.res_vec); else pass_cnt++;
    chk_cnt++; if ({bus.eng_cmd, bus.eng_vec, bus.eng_mask} !== '0)
      $display("FAIL reset_eng: got %h exp 0", {bus.eng_cmd, bus.eng_vec, bus.eng_mask}); else pass_cnt++;
    // a stray done while idle must be ignored
    pulse_done(22'h3FFFFF);
    tick(); tick();
    chk_cnt++; if (bus.res_count !== 4'd0) $display("FAIL idle_done_res: got %0d exp 0", bus.res_count); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL idle_done_busy: got %b exp 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_sendvec_nomask();
    do_reset();
    stage(22'h2AAAAA, 22'h0);
    push(3'd3);                       // strobe was in cycle k, now in k+1
    chk_cnt++; if (bus.eng_start !== 1'b0) $display("FAIL t1_start_early: got %b exp 0", bus.eng_start); else pass_cnt++;
    tick();                           // cycle k+2
    chk_cnt++; if (bus.eng_start !== 1'b1) $display("FAIL t1_start_k2: got %b exp 1", bus.eng_start); else pass_cnt++;
    chk_cnt++; if (bus.eng_cmd !== 3'd3) $display("FAIL t1_eng_cmd: got %0d exp 3", bus.eng_cmd); else pass_cnt++;
    chk_cnt++; if (bus.eng_vec !== 22'h2AAAAA) $display("FAIL t1_eng_vec: got %h exp 2aaaaa", bus.eng_vec); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.eng_start !== 1'b0) $display("FAIL t1_start_one_cycle: got %b exp 0", bus.eng_start); else pass_cnt++;
    tick();
    pulse_done(VEC_W'($urandom));
    tick(); tick(); tick();
    chk_cnt++; if (bus.res_count !== 4'd0) $display("FAIL t1_res_count: got %0d exp 0", bus.res_count); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL t1_busy: got %b exp 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_result_path();
    bit ok;
    do_reset();
    stage(VEC_W'($urandom), 22'h0000FF);
    push(3'd3);
    wait_starts(1, ok);
    chk_cnt++; if (!ok) $display("FAIL t2_start_timeout: got %0d starts exp 1", start_log.size()); else pass_cnt++;
    chk_cnt++; if (bus.eng_mask !== 22'h0000FF) $display("FAIL t2_eng_mask: got %h exp 0000ff", bus.eng_mask); else pass_cnt++;
    pulse_done(22'h0000A5);           // done in cycle d, now d+1
    chk_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL t2_valid_d1: got %b exp 0", bus.res_valid); else pass_cnt++;
    tick();                           // d+2
    chk_cnt++; if (bus.res_valid !== 1'b1) $display("FAIL t2_valid_d2: got %b exp 1", bus.res_valid); else pass_cnt++;
    chk_cnt++; if (bus.res_vec !== 22'h0000A5) $display("FAIL t2_res_vec: got %h exp 0000a5", bus.res_vec); else pass_cnt++;
    pop_res();
    chk_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL t2_valid_after_pop: got %b exp 0", bus.res_valid); else pass_cnt++;
    chk_cnt++; if (bus.res_vec !== '0) $display("FAIL t2_vec_after_pop: got %h exp 0", bus.res_vec); else pass_cnt++;
    pop_res();                        // pop while empty is ignored
    chk_cnt++; if (bus.res_count !== 4'd0) $display("FAIL t2_pop_empty: got %0d exp 0", bus.res_count); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    stage(VEC_W'($urandom) | 22'h1, VEC_W'($urandom));
    for (int i = 0; i < 10; i++) push(CMD_W'($urandom_range(0, 7)));
    tick(); tick();
    chk_cnt++; if (bus.cmd_count !== 4'd8) $display("FAIL t3_cmd_count: got %0d exp 8", bus.cmd_count); else pass_cnt++;
    chk_cnt++; if (bus.ovf !== 1'b1) $display("FAIL t3_ovf_set: got %b exp 1", bus.ovf); else pass_cnt++;
    chk_cnt++; if (start_log.size() != 1) $display("FAIL t3_starts: got %0d exp 1", start_log.size()); else pass_cnt++;
    wr_byte(3'd7, 8'h02);
    chk_cnt++; if (bus.ovf !== 1'b0) $display("FAIL t3_ovf_clear: got %b exp 0", bus.ovf); else pass_cnt++;
    chk_cnt++; if (bus.cmd_count !== 4'd8) $display("FAIL t3_count_kept: got %0d exp 8", bus.cmd_count); else pass_cnt++;
  endtask

  task automatic test_result_stall();
    bit ok;
    logic [VEC_W-1:0] r;
    do_reset();
    stage(VEC_W'($urandom), VEC_W'($urandom) | 22'h100);
    for (int i = 0; i < 9; i++) push(3'd3);
    for (int i = 1; i <= 9; i++) begin
      wait_starts(i, ok);
      chk_cnt++; if (!ok) $display("FAIL t4_start_timeout: got %0d starts exp %0d", start_log.size(), i); else pass_cnt++;
      r = VEC_W'($urandom);
      exp_q.push_back(r);
      pulse_done(r);
    end
    repeat (6) tick();
    chk_cnt++; if (bus.res_count !== 4'd8) $display("FAIL t4_res_full: got %0d exp 8", bus.res_count); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL t4_busy_stall: got %b exp 1", bus.busy); else pass_cnt++;
    chk_cnt++; if (start_log.size() != 9) $display("FAIL t4_no_extra_start: got %0d exp 9", start_log.size()); else pass_cnt++;
    chk_cnt++; if (bus.res_vec !== exp_q[0]) $display("FAIL t4_head: got %h exp %h", bus.res_vec, exp_q[0]); else pass_cnt++;
    void'(exp_q.pop_front());
    pop_res();
    tick(); tick();
    chk_cnt++; if (bus.res_count !== 4'd8) $display("FAIL t4_ninth_lands: got %0d exp 8", bus.res_count); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL t4_busy_after: got %b exp 0", bus.busy); else pass_cnt++;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk_cnt++; if (bus.res_vec !== r) $display("FAIL t4_drain: got %h exp %h", bus.res_vec, r); else pass_cnt++;
      pop_res();
    end
    chk_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL t4_empty: got %b exp 0", bus.res_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    bit ok;
    do_reset();
    stage(VEC_W'($urandom), VEC_W'($urandom) | 22'h1);
    for (int i = 0; i < 3; i++) push(3'd3);
    wait_starts(1, ok);
    chk_cnt++; if (!ok) $display("FAIL t5_start_timeout: got %0d starts exp 1", start_log.size()); else pass_cnt++;
    chk_cnt++; if (bus.cmd_count !== 4'd2) $display("FAIL t5_count_pre: got %0d exp 2", bus.cmd_count); else pass_cnt++;
    wr_byte(3'd7, 8'h01);
    chk_cnt++; if (bus.cmd_count !== 4'd0) $display("FAIL t5_count_flushed: got %0d exp 0", bus.cmd_count); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL t5_busy_inflight: got %b exp 1", bus.busy); else pass_cnt++;
    pulse_done(VEC_W'($urandom) | 22'h1);
    repeat (4) tick();
    chk_cnt++; if (bus.res_count !== 4'd0) $display("FAIL t5_no_result: got %0d exp 0", bus.res_count); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL t5_idle: got %b exp 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (start_log.size() != 1) $display("FAIL t5_starts: got %0d exp 1", start_log.size()); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    stage(VEC_W'($urandom) | 22'h1, VEC_W'($urandom) | 22'h1);
    push(3'd3);
    push(3'd3);
    wait_starts(1, ok);
    pulse_done(VEC_W'($urandom));
    wait_starts(2, ok);
    chk_cnt++; if (!ok) $display("FAIL t6_start_timeout: got %0d starts exp 2", start_log.size()); else pass_cnt++;
    chk_cnt++; if (bus.res_count !== 4'd1) $display("FAIL t6_pre_res: got %0d exp 1", bus.res_count); else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;                               // still well before the next edge
    chk_cnt++; if ({bus.res_valid, bus.res_count, bus.cmd_count, bus.ovf, bus.busy, bus.eng_start} !== '0)
      $display("FAIL t6_async_status: got %h exp 0", {bus.res_valid, bus.res_count, bus.cmd_count, bus.ovf, bus.busy, bus.eng_start}); else pass_cnt++;
    chk_cnt++; if ({bus.eng_cmd, bus.eng_vec, bus.eng_mask, bus.res_vec} !== '0)
      $display("FAIL t6_async_data: got %h exp 0", {bus.eng_cmd, bus.eng_vec, bus.eng_mask, bus.res_vec}); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_done(VEC_W'($urandom));
    repeat (3) tick();
    chk_cnt++; if (bus.res_count !== 4'd0) $display("FAIL t6_done_ignored: got %0d exp 0", bus.res_count); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL t6_busy: got %b exp 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (start_log.size() != 2) $display("FAIL t6_starts: got %0d exp 2", start_log.size()); else pass_cnt++;
  endtask

  // Reference model: commands issue in push order, one at a time; a result is
  // kept only for SENDVEC (cmd 3) with a non-zero mask.
  task automatic test_random();
    ent_t             model_q[$];
    ent_t             e;
    int               n;
    bit               ok;
    logic [VEC_W-1:0] r;
    for (int round = 0; round < 5; round++) begin
      do_reset();
      model_q.delete();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        e.cmd  = ($urandom_range(0, 1) == 1) ? CMD_W'(3) : CMD_W'($urandom_range(0, 7));
        e.vec  = VEC_W'($urandom);
        e.mask = ($urandom_range(0, 3) == 0) ? '0 : VEC_W'($urandom);
        stage(e.vec, e.mask);
        push(e.cmd);
        model_q.push_back(e);
      end
      tick(); tick();
      chk_cnt++; if (bus.cmd_count !== 4'(n - 1)) $display("FAIL rnd_cmd_count: got %0d exp %0d", bus.cmd_count, n - 1); else pass_cnt++;
      for (int i = 0; i < n; i++) begin
        wait_starts(i + 1, ok);
        chk_cnt++;
        if (!ok) $display("FAIL rnd_start_timeout: got %0d starts exp %0d", start_log.size(), i + 1);
        else if (start_log[i] !== model_q[i]) $display("FAIL rnd_issue: got %h exp %h", start_log[i], model_q[i]);
        else pass_cnt++;
        repeat ($urandom_range(0, 3)) tick();
        r = VEC_W'($urandom);
        pulse_done(r);
        if (model_q[i].cmd == 3'd3 && model_q[i].mask != '0) exp_q.push_back(r);
      end
      repeat (4) tick();
      chk_cnt++; if (bus.res_count !== 4'(exp_q.size())) $display("FAIL rnd_res_count: got %0d exp %0d", bus.res_count, exp_q.size()); else pass_cnt++;
      chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL rnd_busy: got %b exp 0", bus.busy); else pass_cnt++;
      while (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk_cnt++; if (bus.res_vec !== r) $display("FAIL rnd_result: got %h exp %h", bus.res_vec, r); else pass_cnt++;
        pop_res();
      end
      chk_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL rnd_drained: got %b exp 0", bus.res_valid); else pass_cnt++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.wr_en      = 1'b0;
    bus.wr_sel     = 3'd0;
    bus.wr_data    = 8'd0;
    bus.res_pop    = 1'b0;
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    test_reset();
    test_sendvec_nomask();
    test_result_path();
    test_overflow();
    test_result_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
